// File: rtl/disp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Purpose  : Shared types, constants and the digit-enable decoder for the
//            seven-segment bus receiver.
// Contents : seg_t      - one digit's segment byte
//            AN_BLANK   - digit-enable pattern with no digit selected
//            an_dec_t   - decode result {legal, idx}
//            an_decode  - maps a one-hot-low enable onto a digit index
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

   typedef logic [7:0] seg_t;

   localparam logic [3:0] AN_BLANK = 4'b1111;

   typedef struct packed {
      logic       legal;
      logic [1:0] idx;
   } an_dec_t;

   // Only the four one-hot-low codes select a digit; everything else,
   // including the blank code, reports legal=0.
   function automatic an_dec_t an_decode(input logic [3:0] an);
      an_dec_t d;
      d.legal = 1'b1;
      d.idx   = 2'd0;
      case (an)
         4'b1110: d.idx = 2'd0;
         4'b1101: d.idx = 2'd1;
         4'b1011: d.idx = 2'd2;
         4'b0111: d.idx = 2'd3;
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/disp_demux_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchroniser for a bus that is asynchronous to clk.
//            Resets to all-ones, which is the idle (blank) level of the
//            seven-segment bus.
// Ports    : clk   - system clock
//            reset - asynchronous active-low reset
//            i_d   - asynchronous input bus [W-1:0]
//            o_q   - synchronised output bus [W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= '1;
         r_s2 <= '1;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/disp_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : disp_demux
// Purpose  : Receiver for a 4-digit time-multiplexed seven-segment bus.
//            Synchronises {an,sseg}, waits for the bus to hold still for
//            SETTLE cycles, then files the segment byte under the digit
//            selected by the active-low enable. Tracks per-digit validity,
//            emits a pulse per completed frame, flags illegal enables and
//            invalidates everything if the bus goes stale.
// Ports    : clk        - system clock
//            reset      - asynchronous active-low reset
//            an_in      - digit enables, active-low (asynchronous)
//            sseg_in    - segment pattern (asynchronous)
//            out0..out3 - last captured segment byte per digit
//            dvalid     - per-digit "captured since reset/timeout" flags
//            frame_tick - pulse when all four digits have been captured
//            an_err     - pulse when a stable illegal enable is seen
// Revision : 1.0 - initial release
// ============================================================================
module disp_demux
   import disp_pkg::*;
#(
   parameter int SETTLE    = 4,
   parameter int TIMEOUT_W = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an_in,
   input  logic [7:0] sseg_in,
   output logic [7:0] out0,
   output logic [7:0] out1,
   output logic [7:0] out2,
   output logic [7:0] out3,
   output logic [3:0] dvalid,
   output logic       frame_tick,
   output logic       an_err
);

   localparam int                   CW          = $clog2(SETTLE + 1);
   localparam logic [CW-1:0]        c_settle    = CW'(SETTLE);
   localparam logic [CW-1:0]        c_settle_m1 = CW'(SETTLE - 1);
   localparam logic [TIMEOUT_W-1:0] c_wd_max    = '1;

   logic [11:0]          w_sync;
   logic [11:0]          r_prev;
   logic [CW-1:0]        r_cnt;
   logic                 r_stable;
   seg_t                 r_out [0:3];
   logic [3:0]           r_dvalid;
   logic [3:0]           r_seen;
   logic                 r_frame;
   logic                 r_err;
   logic [TIMEOUT_W-1:0] r_wdog;

   an_dec_t              w_dec;
   logic                 w_capture;
   logic                 w_illegal;
   logic [3:0]           w_onehot;
   logic [3:0]           w_seen_next;

   sync2 #(.W(12)) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   ({an_in, sseg_in}),
      .o_q   (w_sync)
   );

   // Settle filter. r_stable fires for exactly one cycle per quiet period:
   // it is set on the edge where the counter steps from SETTLE-1 to SETTLE,
   // and a saturated counter never revisits SETTLE-1. The capture itself
   // happens one edge later, from r_prev, which still holds the settled value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev   <= '1;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_prev   <= w_sync;
         r_stable <= (w_sync == r_prev) && (r_cnt == c_settle_m1);
         if (w_sync != r_prev) begin
            r_cnt <= '0;
         end else if (r_cnt != c_settle) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_dec       = an_decode(r_prev[11:8]);
      w_capture   = r_stable && w_dec.legal;
      w_illegal   = r_stable && !w_dec.legal && (r_prev[11:8] != AN_BLANK);
      w_onehot    = 4'b0001 << w_dec.idx;
      w_seen_next = r_seen | w_onehot;
   end

   // Capture, frame tracking and watchdog. A capture takes priority over a
   // watchdog expiry in the same cycle. Segment bytes survive an expiry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            r_out[i] <= '0;
         end
         r_dvalid <= '0;
         r_seen   <= '0;
         r_frame  <= 1'b0;
         r_err    <= 1'b0;
         r_wdog   <= '0;
      end else begin
         r_frame <= 1'b0;
         r_err   <= w_illegal;
         if (w_capture) begin
            r_out[w_dec.idx] <= r_prev[7:0];
            r_dvalid         <= r_dvalid | w_onehot;
            r_wdog           <= '0;
            if (w_seen_next == 4'b1111) begin
               r_frame <= 1'b1;
               r_seen  <= '0;
            end else begin
               r_seen  <= w_seen_next;
            end
         end else if (r_wdog == c_wd_max) begin
            r_dvalid <= '0;
            r_seen   <= '0;
         end else begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign out0       = r_out[0];
   assign out1       = r_out[1];
   assign out2       = r_out[2];
   assign out3       = r_out[3];
   assign dvalid     = r_dvalid;
   assign frame_tick = r_frame;
   assign an_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_disp_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_disp_demux
// Purpose  : Self-checking bench for disp_demux. A reference model works
//            from the history of pin values per clock edge: a digit is
//            captured when the pins held one value for exactly SETTLE+1
//            edges, seen LAT edges later. Directed scenarios plus a random
//            bus with glitches, illegal codes, long idles and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_demux;

   localparam int SETTLE = 4;
   localparam int TW     = 6;
   localparam int TMAX   = (1 << TW) - 1;
   localparam int LAT    = 3;
   localparam int HDEPTH = 16384;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] an_in = 4'hF;
   logic [7:0] sseg_in = 8'hFF;
   logic [7:0] out0, out1, out2, out3;
   logic [3:0] dvalid;
   logic       frame_tick, an_err;

   always #5 clk = ~clk;

   disp_demux #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
      .clk        (clk),
      .reset      (reset),
      .an_in      (an_in),
      .sseg_in    (sseg_in),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .dvalid     (dvalid),
      .frame_tick (frame_tick),
      .an_err     (an_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [11:0] hist [0:HDEPTH-1];
   int          e_idx = 0;
   logic [7:0]  m_out [0:3];
   logic [3:0]  m_dvalid = 4'h0;
   logic [3:0]  m_seen = 4'h0;
   logic        m_frame = 1'b0;
   logic        m_err = 1'b0;
   int          m_lastcap = -1;
   int          frame_cnt = 0;
   int          err_cnt = 0;
   logic [7:0]  out3_at_tick = 8'h00;

   function automatic logic [11:0] hist_at(input int i);
      return (i < 0) ? 12'hFFF : hist[i];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 4; d++) m_out[d] = 8'h00;
      m_dvalid  = 4'h0;
      m_seen    = 4'h0;
      m_frame   = 1'b0;
      m_err     = 1'b0;
      m_lastcap = -1;
      e_idx     = 0;
   endtask

   task automatic model_step();
      logic [11:0] w;
      logic [3:0]  a;
      bit          run;
      bit          cap;
      if (e_idx >= HDEPTH) begin
         $display("FAIL hist_depth: observed %0d expected below %0d", e_idx, HDEPTH);
         $fatal(1, "history overflow");
      end
      hist[e_idx] = {an_in, sseg_in};
      w   = hist_at(e_idx - LAT);
      run = 1'b1;
      for (int i = 1; i <= SETTLE; i++)
         if (hist_at(e_idx - LAT - i) != w) run = 1'b0;
      if (hist_at(e_idx - LAT - SETTLE - 1) == w) run = 1'b0;
      m_frame = 1'b0;
      m_err   = 1'b0;
      cap     = 1'b0;
      if (run) begin
         a = w[11:8];
         if ($countones(~a) == 1) begin
            for (int d = 0; d < 4; d++) begin
               if (!a[d]) begin
                  m_out[d]    = w[7:0];
                  m_dvalid[d] = 1'b1;
                  m_seen[d]   = 1'b1;
               end
            end
            cap       = 1'b1;
            m_lastcap = e_idx;
            if (m_seen == 4'hF) begin
               m_frame = 1'b1;
               m_seen  = 4'h0;
            end
         end else if (a != 4'hF) begin
            m_err = 1'b1;
         end
      end
      if (!cap && (e_idx - 1 - m_lastcap) >= TMAX) begin
         m_dvalid = 4'h0;
         m_seen   = 4'h0;
      end
      e_idx++;
   endtask

   // Per-edge monitor: sample the pins at the edge, compare 1 ns later.
   always @(posedge clk) begin
      if (!reset) begin
         model_reset();
         #1;
         check("rst_outs",  {out3, out2, out1, out0}, 32'h0);
         check("rst_dvalid", {28'h0, dvalid}, 32'h0);
         check("rst_frame",  {31'h0, frame_tick}, 32'h0);
         check("rst_err",    {31'h0, an_err}, 32'h0);
      end else begin
         model_step();
         #1;
         check("outs",   {out3, out2, out1, out0}, {m_out[3], m_out[2], m_out[1], m_out[0]});
         check("dvalid", {28'h0, dvalid}, {28'h0, m_dvalid});
         check("frame",  {31'h0, frame_tick}, {31'h0, m_frame});
         check("an_err", {31'h0, an_err}, {31'h0, m_err});
         if (frame_tick) begin
            frame_cnt++;
            out3_at_tick = out3;
         end
         if (an_err) err_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   // Called at a negedge; holds the value for n sampling edges.
   task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
      an_in   = a;
      sseg_in = s;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Scan of four digits from reset
      frame_cnt = 0;
      drive(4'b1110, 8'hC0, 8);
      drive(4'b1101, 8'hF9, 8);
      drive(4'b1011, 8'hA4, 8);
      drive(4'b0111, 8'hB0, 8);
      drive(4'hF, 8'hFF, 12);
      check("scan_out", {out3, out2, out1, out0}, 32'hB0A4F9C0);
      check("scan_dvalid", {28'h0, dvalid}, 32'hF);
      check("scan_frames", frame_cnt, 1);
      check("scan_tick_out3", {24'h0, out3_at_tick}, 32'hB0);

      // Latency: new value appears at edge k+7, not k+6
      an_in   = 4'b1110;
      sseg_in = 8'h92;
      repeat (7) @(negedge clk);
      check("lat_k6", {24'h0, out0}, 32'hC0);
      @(negedge clk);
      check("lat_k7", {24'h0, out0}, 32'h92);
      drive(4'hF, 8'hFF, 10);

      // Glitch: 3 cycles rejected, 5 cycles captured
      drive(4'b1101, 8'h99, 3);
      drive(4'hF, 8'hFF, 12);
      check("glitch_out1", {24'h0, out1}, 32'hF9);
      check("glitch_dvalid", {28'h0, dvalid}, 32'hF);
      drive(4'b1101, 8'h99, 5);
      drive(4'hF, 8'hFF, 12);
      check("settle5_out1", {24'h0, out1}, 32'h99);

      // Illegal enable: one pulse; blank: none
      err_cnt = 0;
      drive(4'b1100, 8'h5A, 10);
      drive(4'hF, 8'hFF, 12);
      check("illegal_pulses", err_cnt, 1);
      check("illegal_outs", {out3, out2, out1, out0}, 32'hB0A499_92);
      err_cnt = 0;
      drive(4'hF, 8'h00, 20);
      drive(4'hF, 8'hFF, 10);
      check("blank_pulses", err_cnt, 0);

      // Watchdog after a full frame
      drive(4'b1110, 8'h3F, 8);
      drive(4'b1101, 8'h06, 8);
      drive(4'b1011, 8'h5B, 8);
      drive(4'b0111, 8'h4F, 8);
      drive(4'hF, 8'hFF, 40);
      check("wd_before", {28'h0, dvalid}, 32'hF);
      drive(4'hF, 8'hFF, 40);
      check("wd_expired", {28'h0, dvalid}, 32'h0);
      check("wd_outs_kept", {out3, out2, out1, out0}, 32'h4F5B063F);
      frame_cnt = 0;
      drive(4'b1101, 8'h55, 8);
      drive(4'hF, 8'hFF, 10);
      check("wd_recap_dvalid", {28'h0, dvalid}, 32'h2);
      check("wd_recap_frames", frame_cnt, 0);
      check("wd_recap_out1", {24'h0, out1}, 32'h55);

      // Reset mid-frame discards the partial frame
      drive(4'b1110, 8'h11, 8);
      drive(4'b1101, 8'h22, 8);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid_outs", {out3, out2, out1, out0}, 32'h0);
      check("rstmid_dvalid", {28'h0, dvalid}, 32'h0);
      reset = 1'b1;
      frame_cnt = 0;
      drive(4'b1011, 8'h33, 8);
      drive(4'b0111, 8'h44, 8);
      drive(4'b1110, 8'h55, 8);
      drive(4'b1101, 8'h66, 8);
      drive(4'hF, 8'hFF, 10);
      check("rstmid_frames", frame_cnt, 1);

      // Random bus traffic
      for (int n = 0; n < 700; n++) begin
         int         r;
         logic [3:0] a;
         r = int'($urandom_range(0, 99));
         if (r < 60)      a = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
         else if (r < 75) a = 4'hF;
         else             a = 4'($urandom);
         drive(a, 8'($urandom), int'($urandom_range(1, 10)));
         if ($urandom_range(0, 49) == 0)
            drive(4'hF, 8'hFF, int'($urandom_range(60, 90)));
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
         end
      end
      drive(4'hF, 8'hFF, 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
